// File: rtl/event_monitor_mc_pkg.sv
// Shared types and helpers for the multi-channel event monitor.
// Covers the FSM state encoding, trigger-mode codes, width helpers and the default event word layout.
package event_monitor_mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } mon_state_e;

    localparam logic [1:0] MODE_EQ     = 2'd0;
    localparam logic [1:0] MODE_NE     = 2'd1;
    localparam logic [1:0] MODE_RISE   = 2'd2;
    localparam logic [1:0] MODE_CHANGE = 2'd3;

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int evt_width(input int ts_w, input int num_ch, input int probe_w);
        return ts_w + ch_width(num_ch) + probe_w;
    endfunction

    // Event word for the default geometry (TS_W=16, NUM_CH=4, PROBE_W=8).
    typedef struct packed {
        logic [15:0] ts;
        logic [1:0]  ch;
        logic [7:0]  data;
    } evt_word_t;

endpackage

// File: rtl/event_fifo_sa.sv
// Show-ahead FIFO: the head word is visible on dout while the FIFO is non-empty.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module event_fifo_sa #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH) + 1
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LVL_W-1:0] level_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level_reg == '0);
    assign full    = (level_reg == LVL_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign level   = level_reg;
    // Stale RAM contents are hidden so the head reads zero when empty.
    assign dout    = empty ? '0 : mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_reg <= level_reg + LVL_W'(1);
                2'b01:   level_reg <= level_reg - LVL_W'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

endmodule

// File: rtl/event_monitor_mc.sv
// Multi-channel event monitor: masked per-channel triggers, round-robin capture
// of timestamped {ts, ch, data} words into a shared show-ahead FIFO.
module event_monitor_mc
    import event_monitor_mc_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int PROBE_W    = 8,
    parameter int TS_W       = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int POST_W     = 8,
    parameter int CH_W       = ch_width(NUM_CH),
    parameter int EVT_W      = evt_width(TS_W, NUM_CH, PROBE_W),
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      arm,
    input  logic                      clear,
    input  logic [NUM_CH-1:0]         ch_enable,
    input  logic [2*NUM_CH-1:0]       trig_mode,
    input  logic [NUM_CH*PROBE_W-1:0] trig_value,
    input  logic [NUM_CH*PROBE_W-1:0] trig_mask,
    input  logic [POST_W-1:0]         post_len,
    input  logic [NUM_CH*PROBE_W-1:0] probe_data,
    input  logic                      evt_pop,
    output logic [EVT_W-1:0]          evt_data,
    output logic                      evt_valid,
    output logic [LVL_W-1:0]          fifo_level,
    output logic [1:0]                state,
    output logic                      triggered_sticky,
    output logic [CH_W-1:0]           trig_ch,
    output logic                      fifo_overflow_sticky,
    output logic [15:0]               drop_count
);
    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_ARMED   = ST_ARMED;
    localparam logic [1:0] S_CAPTURE = ST_CAPTURE;
    localparam logic [1:0] S_DONE    = ST_DONE;

    logic [TS_W-1:0]           ts_reg;
    logic [NUM_CH*PROBE_W-1:0] prev_reg;
    logic [CH_W-1:0]           ptr_reg;
    logic [1:0]                state_reg;
    logic [POST_W-1:0]         rem_reg;
    logic                      unl_reg;
    logic                      cand_valid_reg;
    logic [EVT_W-1:0]          cand_reg;
    logic                      trig_reg;
    logic [CH_W-1:0]           trig_ch_reg;
    logic                      ovf_reg;
    logic [15:0]               drop_reg;

    logic [NUM_CH-1:0] match;
    logic              grant_ok;
    logic [CH_W-1:0]   grant_idx;
    logic [CH_W-1:0]   ptr_next;
    logic [CH_W:0]     n_match;
    int                idx;
    logic              capture_now;
    logic              trigger_now;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push_lost;
    logic [CH_W:0]     contention;
    logic [CH_W+1:0]   drop_inc;
    logic [16:0]       drop_sum;
    logic [15:0]       drop_next;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_match
        logic [PROBE_W-1:0] p, v, m, pv;
        logic [1:0]         md;
        logic               hit;
        assign p  = probe_data[gi*PROBE_W +: PROBE_W];
        assign v  = trig_value[gi*PROBE_W +: PROBE_W];
        assign m  = trig_mask[gi*PROBE_W +: PROBE_W];
        assign pv = prev_reg[gi*PROBE_W +: PROBE_W];
        assign md = trig_mode[gi*2 +: 2];
        always_comb begin
            case (md)
                MODE_EQ:   hit = ((p & m) == (v & m));
                MODE_NE:   hit = ((p & m) != (v & m));
                MODE_RISE: hit = |(p & ~pv & m);
                default:   hit = |((p ^ pv) & m);
            endcase
        end
        assign match[gi] = ch_enable[gi] & hit;
    end

    // Search starts at the round-robin pointer and wraps past the top channel.
    always_comb begin
        grant_ok  = 1'b0;
        grant_idx = '0;
        n_match   = '0;
        idx       = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            n_match = n_match + (CH_W+1)'(match[i]);
            idx = int'(ptr_reg) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!grant_ok && match[idx[CH_W-1:0]]) begin
                grant_ok  = 1'b1;
                grant_idx = idx[CH_W-1:0];
            end
        end
    end

    assign ptr_next    = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
    assign capture_now = en & ((state_reg == S_ARMED) | (state_reg == S_CAPTURE)) & grant_ok;
    assign trigger_now = en & (state_reg == S_ARMED) & grant_ok;
    assign push_lost   = cand_valid_reg & fifo_full & ~(evt_pop & ~fifo_empty);
    assign contention  = capture_now ? (n_match - (CH_W+1)'(1)) : '0;
    assign drop_inc    = {1'b0, contention} + (CH_W+2)'(push_lost);
    assign drop_sum    = {1'b0, (clear ? 16'd0 : drop_reg)} + 17'(drop_inc);
    assign drop_next   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_reg         <= '0;
            prev_reg       <= '0;
            ptr_reg        <= '0;
            state_reg      <= S_IDLE;
            rem_reg        <= '0;
            unl_reg        <= 1'b0;
            cand_valid_reg <= 1'b0;
            cand_reg       <= '0;
            trig_reg       <= 1'b0;
            trig_ch_reg    <= '0;
            ovf_reg        <= 1'b0;
            drop_reg       <= '0;
        end else begin
            prev_reg       <= probe_data;
            cand_valid_reg <= capture_now;
            trig_reg       <= (trig_reg & ~clear) | trigger_now;
            ovf_reg        <= (ovf_reg & ~clear) | push_lost;
            drop_reg       <= drop_next;
            if (en) begin
                ts_reg <= ts_reg + TS_W'(1);
            end
            if (capture_now) begin
                ptr_reg  <= ptr_next;
                cand_reg <= {ts_reg, grant_idx, probe_data[grant_idx*PROBE_W +: PROBE_W]};
            end
            if (trigger_now) begin
                trig_ch_reg <= grant_idx;
            end
            if (!en) begin
                state_reg <= S_IDLE;
            end else begin
                case (state_reg)
                    S_IDLE: if (arm) state_reg <= S_ARMED;
                    S_ARMED: begin
                        // rem_reg counts events still owed after the trigger word.
                        if (grant_ok) begin
                            unl_reg   <= (post_len == '0);
                            rem_reg   <= post_len - POST_W'(1);
                            state_reg <= (post_len == POST_W'(1)) ? S_DONE : S_CAPTURE;
                        end
                    end
                    S_CAPTURE: begin
                        if (grant_ok && !unl_reg) begin
                            rem_reg <= rem_reg - POST_W'(1);
                            if (rem_reg == POST_W'(1)) begin
                                state_reg <= S_DONE;
                            end
                        end
                    end
                    default: if (arm) state_reg <= S_ARMED;
                endcase
            end
        end
    end

    event_fifo_sa #(
        .W     (EVT_W),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cand_valid_reg),
        .pop   (evt_pop),
        .din   (cand_reg),
        .dout  (evt_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign evt_valid            = ~fifo_empty;
    assign state                = state_reg;
    assign triggered_sticky     = trig_reg;
    assign trig_ch              = trig_ch_reg;
    assign fifo_overflow_sticky = ovf_reg;
    assign drop_count           = drop_reg;

endmodule

// File: tb/tb_event_monitor_mc.sv
// Directed and randomized bench for event_monitor_mc against an event-level reference model.
module tb_event_monitor_mc;
    import event_monitor_mc_pkg::*;

    localparam int NCH   = 4;
    localparam int DEPTH = 4;
    localparam int EVT_W = 26;

    logic              clk = 1'b0;
    logic              rst_n, en, arm, clear, evt_pop;
    logic [NCH-1:0]    ch_enable;
    logic [2*NCH-1:0]  trig_mode;
    logic [NCH*8-1:0]  trig_value, trig_mask, probe_data;
    logic [7:0]        post_len;
    logic [EVT_W-1:0]  evt_data;
    logic              evt_valid, triggered_sticky, fifo_overflow_sticky;
    logic [2:0]        fifo_level;
    logic [1:0]        state, trig_ch;
    logic [15:0]       drop_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int               m_ts, m_ptr, m_state, m_trig_ch, m_drop, m_rem;
    bit               m_trig, m_ovf, m_unl, m_cv;
    logic [7:0]       m_prev [NCH];
    logic [EVT_W-1:0] m_cand;
    logic [EVT_W-1:0] m_q [$];

    evt_word_t w;
    int ts_exp;

    always #5 clk = ~clk;

    event_monitor_mc #(
        .NUM_CH(NCH), .PROBE_W(8), .TS_W(16), .FIFO_DEPTH(DEPTH), .POST_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .arm(arm), .clear(clear),
        .ch_enable(ch_enable), .trig_mode(trig_mode), .trig_value(trig_value),
        .trig_mask(trig_mask), .post_len(post_len), .probe_data(probe_data),
        .evt_pop(evt_pop), .evt_data(evt_data), .evt_valid(evt_valid),
        .fifo_level(fifo_level), .state(state), .triggered_sticky(triggered_sticky),
        .trig_ch(trig_ch), .fifo_overflow_sticky(fifo_overflow_sticky), .drop_count(drop_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ts = 0; m_ptr = 0; m_state = 0; m_trig_ch = 0; m_drop = 0; m_rem = 0;
        m_trig = 0; m_ovf = 0; m_unl = 0; m_cv = 0; m_cand = '0;
        for (int c = 0; c < NCH; c++) m_prev[c] = 8'h00;
        m_q.delete();
    endtask

    // One clock of the reference: matches, arbitration, FIFO, counters, control.
    task automatic model_step();
        bit mt [NCH];
        int nm, g, inc;
        bit any, cap, trg, ovf_set;
        logic [7:0] p, v, m, pv;
        nm = 0; g = 0; any = 0; inc = 0; ovf_set = 0;
        for (int c = 0; c < NCH; c++) begin
            p = probe_data[c*8 +: 8]; v = trig_value[c*8 +: 8];
            m = trig_mask[c*8 +: 8];  pv = m_prev[c];
            case (trig_mode[c*2 +: 2])
                2'd0:    mt[c] = ((p & m) == (v & m));
                2'd1:    mt[c] = ((p & m) != (v & m));
                2'd2:    mt[c] = |(p & ~pv & m);
                default: mt[c] = |((p ^ pv) & m);
            endcase
            mt[c] = mt[c] && ch_enable[c];
            if (mt[c]) nm++;
        end
        for (int k = 0; k < NCH; k++) begin
            int c = (m_ptr + k) % NCH;
            if (!any && mt[c]) begin any = 1; g = c; end
        end
        cap = en && (m_state == 1 || m_state == 2) && any;
        trg = cap && (m_state == 1);
        if (evt_pop && m_q.size() > 0) void'(m_q.pop_front());
        if (m_cv) begin
            if (m_q.size() < DEPTH) m_q.push_back(m_cand);
            else begin ovf_set = 1; inc++; end
        end
        m_cv = cap;
        if (cap) begin
            m_cand = {16'(m_ts), 2'(g), probe_data[g*8 +: 8]};
            inc += nm - 1;
            m_ptr = (g + 1) % NCH;
        end
        m_drop = (clear ? 0 : m_drop) + inc;
        if (m_drop > 65535) m_drop = 65535;
        m_ovf  = (clear ? 1'b0 : m_ovf) | ovf_set;
        m_trig = (clear ? 1'b0 : m_trig) | trg;
        if (trg) m_trig_ch = g;
        if (!en) m_state = 0;
        else case (m_state)
            0: if (arm) m_state = 1;
            1: if (any) begin
                m_unl = (post_len == 0);
                m_rem = int'(post_len) - 1;
                m_state = (!m_unl && m_rem == 0) ? 3 : 2;
            end
            2: if (any && !m_unl) begin
                m_rem--;
                if (m_rem == 0) m_state = 3;
            end
            default: if (arm) m_state = 1;
        endcase
        if (en) m_ts = (m_ts + 1) % 65536;
        for (int c = 0; c < NCH; c++) m_prev[c] = probe_data[c*8 +: 8];
    endtask

    task automatic check_all();
        chk("state", 32'(state), 32'(m_state));
        chk("evt_valid", 32'(evt_valid), 32'(m_q.size() > 0));
        chk("fifo_level", 32'(fifo_level), 32'(m_q.size()));
        chk("evt_data", 32'(evt_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'd0);
        chk("triggered", 32'(triggered_sticky), 32'(m_trig));
        chk("trig_ch", 32'(trig_ch), 32'(m_trig_ch));
        chk("overflow", 32'(fifo_overflow_sticky), 32'(m_ovf));
        chk("drop_count", 32'(drop_count), 32'(m_drop));
    endtask

    task automatic step();
        if (evt_pop && evt_valid) begin
            w = evt_data;
            $display("pop  ts=%0d ch=%0d data=%02h level=%0d", w.ts, w.ch, w.data, fifo_level);
        end
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_probe(input int c, input logic [7:0] v);
        probe_data[c*8 +: 8] = v;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; arm = 1'b0; clear = 1'b0; evt_pop = 1'b0;
        ch_enable = '0; trig_mode = '0; trig_value = '0; trig_mask = '0;
        post_len = '0; probe_data = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1; en = 1'b1;
        step();

        // Single-channel masked-equal trigger, one event.
        ch_enable = 4'b0100; trig_mode = '0;
        trig_value = 32'h00A5_0000; trig_mask = 32'h00FF_0000; post_len = 8'd1;
        set_probe(2, 8'h00);
        step();
        arm = 1'b1; step(); arm = 1'b0;
        chk("t1_armed", 32'(state), 32'd1);
        set_probe(2, 8'hA5);
        step();
        chk("t1_trig", 32'(triggered_sticky), 32'd1);
        chk("t1_trig_ch", 32'(trig_ch), 32'd2);
        chk("t1_valid_lat", 32'(evt_valid), 32'd0);
        chk("t1_done", 32'(state), 32'd3);
        step();
        w = evt_data;
        chk("t1_valid", 32'(evt_valid), 32'd1);
        chk("t1_ch", 32'(w.ch), 32'd2);
        chk("t1_data", 32'(w.data), 32'hA5);
        evt_pop = 1'b1; step(); evt_pop = 1'b0;

        // Round-robin contention between ch0 and ch3, unlimited capture.
        ch_enable = 4'b1111; trig_mode = 8'hFF; trig_mask = 32'hFFFF_FFFF;
        trig_value = '0; post_len = 8'd0; probe_data = '0; clear = 1'b1;
        step(); clear = 1'b0;
        arm = 1'b1; step(); arm = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_probe(0, probe_data[7:0] ^ 8'h01);
            set_probe(3, probe_data[31:24] ^ 8'h01);
            step();
        end
        step();
        chk("t2_level", 32'(fifo_level), 32'd4);
        chk("t2_drops", 32'(drop_count), 32'd4);
        // Drop enable mid-capture: FIFO survives and pops still work.
        en = 1'b0; step();
        chk("t5_idle", 32'(state), 32'd0);
        chk("t5_kept", 32'(fifo_level), 32'd4);
        // The earlier ch2 grant left the pointer at 3, so ch3 wins first.
        for (int i = 0; i < 4; i++) begin
            w = evt_data;
            chk("t2_grant", 32'(w.ch), (i % 2 == 0) ? 32'd3 : 32'd0);
            evt_pop = 1'b1; step(); evt_pop = 1'b0;
        end
        repeat (3) step();

        // Rising-edge mask on ch1; re-enable and re-arm from IDLE.
        ch_enable = 4'b0010; trig_mode = 8'h08; trig_mask = 32'h0000_0F00;
        trig_value = '0; post_len = 8'd1; probe_data = '0; set_probe(1, 8'h10);
        en = 1'b1; clear = 1'b1; step(); clear = 1'b0;
        arm = 1'b1; step(); arm = 1'b0;
        chk("t3_armed", 32'(state), 32'd1);
        set_probe(1, 8'h30); step();
        chk("t3_no_trig", 32'(triggered_sticky), 32'd0);
        set_probe(1, 8'h31); ts_exp = m_ts; step();
        chk("t3_trig", 32'(triggered_sticky), 32'd1);
        chk("t3_trig_ch", 32'(trig_ch), 32'd1);
        step();
        w = evt_data;
        chk("t3_data", 32'(w.data), 32'h31);
        chk("t3_ts", 32'(w.ts), 32'(ts_exp));
        evt_pop = 1'b1; step(); evt_pop = 1'b0;

        // Overflow: six events into a four-deep FIFO with no pops.
        ch_enable = 4'b0001; trig_mode = 8'h03; trig_mask = 32'h0000_00FF;
        post_len = 8'd0; set_probe(0, 8'h00); clear = 1'b1; step(); clear = 1'b0;
        arm = 1'b1; step(); arm = 1'b0;
        for (int i = 1; i <= 6; i++) begin set_probe(0, 8'(i)); step(); end
        step();
        chk("t4_level", 32'(fifo_level), 32'd4);
        chk("t4_ovf", 32'(fifo_overflow_sticky), 32'd1);
        chk("t4_drops", 32'(drop_count), 32'd2);
        clear = 1'b1; step(); clear = 1'b0;
        chk("t4_ovf_clr", 32'(fifo_overflow_sticky), 32'd0);
        chk("t4_drop_clr", 32'(drop_count), 32'd0);
        chk("t4_trig_clr", 32'(triggered_sticky), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            w = evt_data;
            chk("t4_order", 32'(w.data), 32'(i));
            evt_pop = 1'b1; step(); evt_pop = 1'b0;
        end

        // Asynchronous reset with three events queued.
        arm = 1'b1; step(); arm = 1'b0;
        for (int i = 7; i <= 9; i++) begin set_probe(0, 8'(i)); step(); end
        step();
        chk("t6_queued", 32'(fifo_level), 32'd3);
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        chk("t6_valid", 32'(evt_valid), 32'd0);
        chk("t6_level", 32'(fifo_level), 32'd0);
        chk("t6_state", 32'(state), 32'd0);
        chk("t6_trig", 32'(triggered_sticky), 32'd0);
        chk("t6_drops", 32'(drop_count), 32'd0);
        chk("t6_data", 32'(evt_data), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        step();
        chk("t6_after", 32'(evt_valid), 32'd0);

        // Randomized traffic against the model.
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (cyc % 64 == 0) begin
                ch_enable  = NCH'($urandom);
                trig_mode  = 8'($urandom);
                trig_value = $urandom & 32'h0303_0303;
                trig_mask  = $urandom | 32'h0101_0101;
                post_len   = 8'($urandom_range(0, 4));
            end
            for (int c = 0; c < NCH; c++)
                if ($urandom_range(0, 3) == 0) set_probe(c, 8'($urandom_range(0, 7)));
            arm     = ($urandom_range(0, 7) == 0);
            clear   = ($urandom_range(0, 19) == 0);
            en      = ($urandom_range(0, 31) != 0);
            evt_pop = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/event_monitor_mc.md
Name: event_monitor_mc

Overview:
- Multi-channel successor to the single-probe event monitor core.
- Watches NUM_CH probe buses, each with its own masked trigger condition.
- Arms on a pulse, fires on the first qualifying channel, then captures a bounded burst of timestamped events from all enabled channels into one shared show-ahead FIFO.
- Sits between the probe taps and the register/readout interface; same event word style as the existing core: {ts, ch, data}.

Parameters:
- NUM_CH, 4, number of probe channels (>=2).
- PROBE_W, 8, width of each probe bus.
- TS_W, 16, free-running timestamp width.
- FIFO_DEPTH, 8, event FIFO entries (power of 2).
- POST_W, 8, width of post-trigger event count.
- Derived: CH_W = max(1, $clog2(NUM_CH)); EVT_W = TS_W + CH_W + PROBE_W; LVL_W = $clog2(FIFO_DEPTH) + 1.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  global enable; 0 forces IDLE and freezes the timestamp.
- arm  in  1  pulse; IDLE/DONE -> ARMED.
- clear  in  1  pulse; clears sticky flags and drop_count.
- ch_enable  in  NUM_CH  per-channel participation mask.
- trig_mode  in  2*NUM_CH  per-channel mode. 0 = masked equal, 1 = masked not-equal, 2 = masked rising edge, 3 = masked any change.
- trig_value  in  NUM_CH*PROBE_W  per-channel compare value.
- trig_mask  in  NUM_CH*PROBE_W  per-channel bit mask.
- post_len  in  POST_W  number of events to capture including the trigger event; 0 = unlimited.
- probe_data  in  NUM_CH*PROBE_W  channel c occupies bits [c*PROBE_W +: PROBE_W].
- evt_pop  in  1  consume FIFO head.
- evt_data  out  EVT_W  FIFO head, {ts, ch, data}, MSB first.
- evt_valid  out  1  FIFO non-empty.
- fifo_level  out  LVL_W  current occupancy.
- state  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
- triggered_sticky  out  1  set on trigger.
- trig_ch  out  CH_W  channel that fired the trigger.
- fifo_overflow_sticky  out  1  set when a push is lost to a full FIFO.
- drop_count  out  16  saturating count of lost events.

Behaviour:
- Reset: all outputs 0, FIFO empty, ts = 0, prev-sample registers 0, round-robin pointer 0, state IDLE.
- Timestamp: ts increments every cycle while en = 1, wraps modulo 2^TS_W, and holds while en = 0.
- Previous sample: prev[c] <= probe_data[c] every cycle, independent of en.
- Match[c] requires ch_enable[c]. With m = trig_mask[c]:
  - mode 0: (probe & m) == (value & m).
  - mode 1: (probe & m) != (value & m).
  - mode 2: |(probe & ~prev & m).
  - mode 3: |((probe ^ prev) & m).
- FSM:
  - IDLE -> ARMED on arm & en.
  - ARMED -> CAPTURE at the edge where any match is sampled. That edge sets triggered_sticky and loads trig_ch with the granted channel.
  - CAPTURE -> DONE when the remaining count reaches 0 (post_len != 0).
  - DONE -> ARMED on arm.
  - en = 0 in any state -> IDLE next edge; FIFO contents are kept and pop still works.
  - arm during ARMED/CAPTURE is ignored.
- Candidates: in the trigger cycle and every CAPTURE cycle, matching channels compete.
  - Round-robin grant: the lowest channel index >= pointer, wrapping; pointer <= grant + 1 mod NUM_CH.
  - The grant loads the candidate register {ts, grant, probe_data[grant]} at that edge.
  - Each non-granted matching channel adds 1 to drop_count in that cycle, saturating at 16'hFFFF.
- Latency: the candidate is written to the FIFO on the following edge. evt_valid rises 1 cycle after triggered_sticky.
- Remaining counter: loaded with post_len at trigger; decremented per granted candidate, the trigger event included.
  - post_len = 1 captures only the trigger event.
  - The last grant moves the FSM to DONE; later matches are neither captured nor counted.
- FIFO is show-ahead:
  - Pop on empty is ignored.
  - Push on full is dropped: sets fifo_overflow_sticky and adds 1 to drop_count.
  - Push with simultaneous pop when full is accepted.
  - Level is unchanged on simultaneous push and pop.
- clear:
  - Zeroes triggered_sticky, fifo_overflow_sticky and drop_count; a same-cycle set or increment wins.
  - Does not touch the FIFO or the FSM.
- Reset mid-capture: immediate return to the reset state, and the FIFO is flushed.

Decomposition:
- Package event_monitor_mc_pkg holds:
  - the state enum;
  - the trig-mode encodings;
  - EVT_W/CH_W helper functions;
  - a packed event struct.
- One sub-module, event_fifo_sa: parametrised show-ahead FIFO with push/pop/full/empty/level.
- Match logic and the arbiter stay inline.

Test Plan:
- Single-channel trigger:
  - Setup: NUM_CH=4, ch_enable=4'b0100, mode 0, value 8'hA5, mask 8'hFF, post_len=1.
  - Stimulus: ch2 data 00 then A5.
  - Required response: triggered_sticky=1, trig_ch=2 at that edge; evt_valid next cycle; ch=2, data=A5; state=DONE.
- Round-robin contention:
  - Setup: all channels mode 3, post_len=0.
  - Stimulus: toggle ch0 and ch3 every cycle for 4 cycles.
  - Required response: grants alternate between ch0 and ch3; drop_count=4.
- Rising-edge mask:
  - Setup: mode 2, mask 8'h0F.
  - Stimulus: data 8'h10 -> 8'h30.
  - Required response: no trigger.
  - Stimulus: data -> 8'h31.
  - Required response: trigger; event data=31; ts equals the timestamp of the sampling edge.
- Overflow:
  - Setup: FIFO_DEPTH=4, mode 3, unlimited capture, no pops.
  - Stimulus: 6 events.
  - Required response: level=4; fifo_overflow_sticky=1; drop_count=2.
  - Stimulus: clear.
  - Required response: flags zeroed; 4 events still poppable in order.
- Re-arm and en drop:
  - Stimulus: en=0 during CAPTURE.
  - Required response: state=IDLE; ts frozen; FIFO kept.
  - Stimulus: en=1, arm.
  - Required response: ARMED; new trigger captured.
- Reset mid-capture:
  - Stimulus: assert rst_n=0 asynchronously with 3 events queued.
  - Required response: all outputs 0 immediately; evt_valid=0 after release.
